runahead_issue_queue: RTL and testbench
=======================================

RUNAHEAD_ISSUE_QUEUE -- requirements
Module: runahead_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter PAYLOAD_W, default 16, opaque instruction payload width.
REQ-003 SHALL have ports: clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have ports: async_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: clk_en  in  1  global advance enable.
REQ-006 SHALL have ports: InstValid  in  1 / InstReady  out  1  decode-side handshake.
REQ-007 SHALL have ports: InstA  in  4  A register index; InstB  in  4  B register index; InstUsesB  in  1  B operand read; InstWritesA  in  1  A is destination; InstMultiCycle  in  1  result arrives via load path; InstPayload  in  PAYLOAD_W.
REQ-008 SHALL have ports: RegDirty  in  16  per-register Dirty from the 16 register state cells.
REQ-009 SHALL have ports: UsedAsA  out  16; UsedAsB  out  16; WillBeWritingToA  out  1; MarkDirty  out  1; IssuedAsA  out  16; IssuedAsB  out  16  state-cell strobes.
REQ-010 SHALL have ports: IssueValid  out  1 / IssueReady  in  1; IssueA  out  4; IssueB  out  4; IssueMultiCycle  out  1; IssuePayload  out  PAYLOAD_W  execute-side handshake.
REQ-011 SHALL have port Count  out  clog2(DEPTH)+1  current occupancy.

Function
REQ-012 SHALL implement an in-order circular FIFO of DEPTH entries {A, B, UsesB, WritesA, MultiCycle, Payload} with head/tail pointers wrapping modulo DEPTH.
REQ-013 InstReady SHALL equal (Count != DEPTH); no push when full, including when a pop occurs that cycle.
REQ-014 Push SHALL occur when InstValid && InstReady && clk_en; entry written at tail, tail advances, Count increments.
REQ-015 In the push cycle (combinationally), UsedAsA SHALL be one-hot at InstA; UsedAsB one-hot at InstB if InstUsesB else zero; WillBeWritingToA = InstWritesA; MarkDirty = InstWritesA && InstMultiCycle.
REQ-016 With no push, UsedAsA, UsedAsB, WillBeWritingToA, MarkDirty SHALL all be 0.
REQ-017 Head SHALL be issuable iff Count != 0 && !RegDirty[headA] && (!headUsesB || !RegDirty[headB]).
REQ-018 IssueValid SHALL equal head-issuable; IssueA/IssueB/IssueMultiCycle/IssuePayload SHALL present head fields whenever Count != 0, zero otherwise.
REQ-019 Pop SHALL occur when IssueValid && IssueReady && clk_en; head advances, Count decrements.
REQ-020 In the pop cycle, IssuedAsA SHALL be one-hot at headA and IssuedAsB one-hot at headB if headUsesB else zero; both zero otherwise.
REQ-021 Simultaneous push and pop SHALL leave Count unchanged and emit both strobe sets in the same cycle, even if A/B indices coincide.
REQ-022 No empty-queue bypass: an entry pushed in cycle N SHALL earliest assert IssueValid in cycle N+1.
REQ-023 clk_en=0 SHALL freeze all state and force every strobe output to 0; InstReady and IssueValid still reflect state.
REQ-024 IssueValid SHALL NOT depend on IssueReady; InstReady SHALL NOT depend on InstValid.

Reset
REQ-025 async_rst SHALL immediately clear head, tail, Count to 0; entry storage need not be cleared.
REQ-026 During and after reset: InstReady=1, IssueValid=0, Count=0, all strobes 0, Issue* data outputs 0.
REQ-027 Reset mid-operation SHALL discard all entries without emitting IssuedAs strobes.

Verification
REQ-028 Push {A=3,B=5,UsesB=1,WritesA=1,MultiCycle=1}, RegDirty=0 -> same cycle UsedAsA=0x0008, UsedAsB=0x0020, MarkDirty=1; next cycle IssueValid=1, IssueA=3.
REQ-029 Fill DEPTH=4 with IssueReady=0 -> Count=4, InstReady=0; fifth InstValid ignored; one pop -> InstReady=1 next cycle.
REQ-030 Head A=7, RegDirty[7]=1 -> IssueValid=0 held; drop RegDirty[7] -> IssueValid=1 same cycle; pop gives IssuedAsA=0x0080.
REQ-031 Count=2, simultaneous push A=1 and pop head A=1 -> UsedAsA=IssuedAsA=0x0002 same cycle, Count stays 2.
REQ-032 Push/pop 10 entries through DEPTH=4 -> payloads issue in order across pointer wrap, Count returns to 0.
REQ-033 Assert async_rst with Count=3 between clock edges -> Count=0, IssueValid=0 immediately, no IssuedAs strobes.

Source files
------------

// File: rtl/runahead_issue_queue.sv
// In-order issue queue between decode and execute for a runahead core; tracks
// register usage strobes toward the 16 register state cells on push and pop.
// Latency: push in cycle N is issuable at the earliest in N+1 (no empty bypass).
// Backpressure: InstReady drops when full (a same-cycle pop does not free a slot);
// the head waits while IssueReady is low or one of its source registers is Dirty.
//
// Ports:
//   clk, async_rst (active-high, asynchronous), clk_en (global advance enable)
//   InstValid/InstReady + InstA/InstB/InstUsesB/InstWritesA/InstMultiCycle/InstPayload
//   RegDirty[15:0]         per-register Dirty from the register state cells
//   UsedAsA/UsedAsB/WillBeWritingToA/MarkDirty   push-cycle strobes
//   IssuedAsA/IssuedAsB                          pop-cycle strobes
//   IssueValid/IssueReady + IssueA/IssueB/IssueMultiCycle/IssuePayload
//   Count                  current occupancy (0..DEPTH)

module runahead_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 16
) (
  input  logic                   clk,
  input  logic                   async_rst,
  input  logic                   clk_en,

  input  logic                   InstValid,
  output logic                   InstReady,
  input  logic [3:0]             InstA,
  input  logic [3:0]             InstB,
  input  logic                   InstUsesB,
  input  logic                   InstWritesA,
  input  logic                   InstMultiCycle,
  input  logic [PAYLOAD_W-1:0]   InstPayload,

  input  logic [15:0]            RegDirty,

  output logic [15:0]            UsedAsA,
  output logic [15:0]            UsedAsB,
  output logic                   WillBeWritingToA,
  output logic                   MarkDirty,
  output logic [15:0]            IssuedAsA,
  output logic [15:0]            IssuedAsB,

  output logic                   IssueValid,
  input  logic                   IssueReady,
  output logic [3:0]             IssueA,
  output logic [3:0]             IssueB,
  output logic                   IssueMultiCycle,
  output logic [PAYLOAD_W-1:0]   IssuePayload,

  output logic [$clog2(DEPTH):0] Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [3:0]           a;
    logic [3:0]           b;
    logic                 uses_b;
    logic                 writes_a;
    logic                 multi_cycle;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  // Entry storage carries no reset: occupancy is defined solely by count_q.
  entry_t mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t in_entry;
  entry_t head_entry;
  logic   full;
  logic   empty;
  logic   head_issuable;
  logic   push_fire;
  logic   pop_fire;

  // WritesA is stored with the entry but nothing downstream of the head needs it.
  logic   unused_head_writes_a;

  // ---------------------------------------------------------------------------
  // Occupancy and head readiness
  // ---------------------------------------------------------------------------
  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    empty      = (count_q == '0);
    head_entry = mem_q[head_q];

    // Stale storage behind an empty queue is masked by the empty term.
    head_issuable = !empty
                    && !RegDirty[head_entry.a]
                    && (!head_entry.uses_b || !RegDirty[head_entry.b]);

    // Full blocks a push even if the head leaves this cycle, so InstReady
    // depends only on state and never on IssueReady/InstValid.
    push_fire = InstValid && !full && clk_en;
    pop_fire  = head_issuable && IssueReady && clk_en;
  end

  assign unused_head_writes_a = head_entry.writes_a;

  always_comb begin
    in_entry             = '0;
    in_entry.a           = InstA;
    in_entry.b           = InstB;
    in_entry.uses_b      = InstUsesB;
    in_entry.writes_a    = InstWritesA;
    in_entry.multi_cycle = InstMultiCycle;
    in_entry.payload     = InstPayload;
  end

  // ---------------------------------------------------------------------------
  // Pointer / count next state; power-of-two depth makes wrap implicit
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (push_fire) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop_fire) begin
      head_d = head_q + PTR_W'(1);
    end

    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[tail_q] <= in_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and data outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    InstReady       = !full;
    IssueValid      = head_issuable;
    Count           = count_q;

    IssueA          = '0;
    IssueB          = '0;
    IssueMultiCycle = 1'b0;
    IssuePayload    = '0;
    if (!empty) begin
      IssueA          = head_entry.a;
      IssueB          = head_entry.b;
      IssueMultiCycle = head_entry.multi_cycle;
      IssuePayload    = head_entry.payload;
    end
  end

  // ---------------------------------------------------------------------------
  // State-cell strobes. Reset is folded in so nothing strobes while async_rst
  // is high, even with InstValid asserted against an empty (ready) queue.
  // Push and pop strobe sets are independent and may name the same register.
  // ---------------------------------------------------------------------------
  always_comb begin
    UsedAsA          = '0;
    UsedAsB          = '0;
    WillBeWritingToA = 1'b0;
    MarkDirty        = 1'b0;
    IssuedAsA        = '0;
    IssuedAsB        = '0;

    if (push_fire && !async_rst) begin
      UsedAsA          = 16'h0001 << InstA;
      UsedAsB          = InstUsesB ? (16'h0001 << InstB) : 16'h0000;
      WillBeWritingToA = InstWritesA;
      // Multi-cycle results land later via the load path, so the destination
      // is marked Dirty at dispatch to hold back dependants.
      MarkDirty        = InstWritesA && InstMultiCycle;
    end

    if (pop_fire && !async_rst) begin
      IssuedAsA = 16'h0001 << head_entry.a;
      IssuedAsB = head_entry.uses_b ? (16'h0001 << head_entry.b) : 16'h0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_count_bound: assert property (@(posedge clk) disable iff (async_rst)
    count_q <= CNT_W'(DEPTH));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (async_rst)
    full |-> !push_fire);

  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (async_rst)
    empty |-> !pop_fire);

endmodule

// File: tb/tb_runahead_issue_queue.sv
module tb_runahead_issue_queue;

  logic        clk;
  logic        async_rst;
  logic        clk_en;
  logic        InstValid;
  logic        InstReady;
  logic [3:0]  InstA;
  logic [3:0]  InstB;
  logic        InstUsesB;
  logic        InstWritesA;
  logic        InstMultiCycle;
  logic [15:0] InstPayload;
  logic [15:0] RegDirty;
  logic [15:0] UsedAsA;
  logic [15:0] UsedAsB;
  logic        WillBeWritingToA;
  logic        MarkDirty;
  logic [15:0] IssuedAsA;
  logic [15:0] IssuedAsB;
  logic        IssueValid;
  logic        IssueReady;
  logic [3:0]  IssueA;
  logic [3:0]  IssueB;
  logic        IssueMultiCycle;
  logic [15:0] IssuePayload;
  logic [2:0]  Count;

  runahead_issue_queue #(.DEPTH(4), .PAYLOAD_W(16)) dut (
    .clk              (clk),
    .async_rst        (async_rst),
    .clk_en           (clk_en),
    .InstValid        (InstValid),
    .InstReady        (InstReady),
    .InstA            (InstA),
    .InstB            (InstB),
    .InstUsesB        (InstUsesB),
    .InstWritesA      (InstWritesA),
    .InstMultiCycle   (InstMultiCycle),
    .InstPayload      (InstPayload),
    .RegDirty         (RegDirty),
    .UsedAsA          (UsedAsA),
    .UsedAsB          (UsedAsB),
    .WillBeWritingToA (WillBeWritingToA),
    .MarkDirty        (MarkDirty),
    .IssuedAsA        (IssuedAsA),
    .IssuedAsB        (IssuedAsB),
    .IssueValid       (IssueValid),
    .IssueReady       (IssueReady),
    .IssueA           (IssueA),
    .IssueB           (IssueB),
    .IssueMultiCycle  (IssueMultiCycle),
    .IssuePayload     (IssuePayload),
    .Count            (Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Inputs change just after a falling edge; checks run 2 time units later,
  // well before the next rising edge.
  task automatic drive(input logic iv, input logic [3:0] a, input logic [3:0] b,
                       input logic ub, input logic wa, input logic mc,
                       input logic [15:0] pl, input logic [15:0] dirty,
                       input logic ir, input logic en);
    InstValid = iv; InstA = a; InstB = b; InstUsesB = ub; InstWritesA = wa;
    InstMultiCycle = mc; InstPayload = pl; RegDirty = dirty; IssueReady = ir;
    clk_en = en;
    #2;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  typedef struct {
    logic        iv;  logic [3:0] a;  logic [3:0] b;
    logic        ub;  logic wa;       logic mc;
    logic [15:0] pl;  logic [15:0] dirty;
    logic        ir;  logic en;
    logic        e_ird;
    logic [15:0] e_ua; logic [15:0] e_ub;
    logic        e_wbw; logic e_md;
    logic [15:0] e_ia; logic [15:0] e_ib;
    logic        e_iv;
    logic [3:0]  e_xa; logic [3:0] e_xb;
    logic        e_xmc;
    logic [15:0] e_xpl;
    logic [2:0]  e_cnt;
  } vec_t;

  function automatic vec_t vi(logic iv, logic [3:0] a, logic [3:0] b, logic ub,
                              logic wa, logic mc, logic [15:0] pl,
                              logic [15:0] dirty, logic ir, logic en);
    vec_t v;
    v = '{default: '0};
    v.iv = iv; v.a = a; v.b = b; v.ub = ub; v.wa = wa; v.mc = mc;
    v.pl = pl; v.dirty = dirty; v.ir = ir; v.en = en;
    return v;
  endfunction

  function automatic vec_t ve(vec_t v, logic ird, logic [15:0] ua, logic [15:0] ubs,
                              logic wbw, logic md, logic [15:0] ia, logic [15:0] ib,
                              logic ivl, logic [3:0] xa, logic [3:0] xb, logic xmc,
                              logic [15:0] xpl, logic [2:0] cnt);
    vec_t r;
    r = v;
    r.e_ird = ird; r.e_ua = ua; r.e_ub = ubs; r.e_wbw = wbw; r.e_md = md;
    r.e_ia = ia; r.e_ib = ib; r.e_iv = ivl; r.e_xa = xa; r.e_xb = xb;
    r.e_xmc = xmc; r.e_xpl = xpl; r.e_cnt = cnt;
    return r;
  endfunction

  vec_t vecs [13];

  initial begin
    logic [15:0] mq [$];
    int pushed;
    int popped;

    //            iv a  b  ub wa mc payload    dirty      ir en
    //            ird usedA     usedB     wbw md issA      issB      iv xa xb mc payload cnt
    vecs[0]  = ve(vi(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1),
                  1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0);
    // push A=3 B=5 multi-cycle writer: strobes now, no bypass to issue
    vecs[1]  = ve(vi(1, 3, 5, 1, 1, 1, 16'hA003, 16'h0000, 1, 1),
                  1, 16'h0008, 16'h0020, 1, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0);
    vecs[2]  = ve(vi(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1),
                  1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 3, 5, 1, 16'hA003, 1);
    // clk_en low: no strobes, no state change, push and pop both suppressed
    vecs[3]  = ve(vi(1, 2, 2, 1, 1, 1, 16'h0BAD, 16'h0000, 1, 0),
                  1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 3, 5, 1, 16'hA003, 1);
    vecs[4]  = ve(vi(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1),
                  1, 16'h0000, 16'h0000, 0, 0, 16'h0008, 16'h0020, 1, 3, 5, 1, 16'hA003, 1);
    // push A=7 with B unused: UsedAsB stays zero
    vecs[5]  = ve(vi(1, 7, 2, 0, 1, 0, 16'h0707, 16'h0080, 1, 1),
                  1, 16'h0080, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0);
    // A register Dirty holds the head
    vecs[6]  = ve(vi(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0080, 1, 1),
                  1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 7, 2, 0, 16'h0707, 1);
    vecs[7]  = ve(vi(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0080, 1, 1),
                  1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 7, 2, 0, 16'h0707, 1);
    // Dirty dropped; unused B register being Dirty does not block
    vecs[8]  = ve(vi(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0004, 1, 1),
                  1, 16'h0000, 16'h0000, 0, 0, 16'h0080, 16'h0000, 1, 7, 2, 0, 16'h0707, 1);
    vecs[9]  = ve(vi(1, 4, 9, 1, 0, 0, 16'h0409, 16'h0000, 0, 1),
                  1, 16'h0010, 16'h0200, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0);
    // used B register Dirty blocks the head
    vecs[10] = ve(vi(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0200, 1, 1),
                  1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 4, 9, 0, 16'h0409, 1);
    vecs[11] = ve(vi(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1),
                  1, 16'h0000, 16'h0000, 0, 0, 16'h0010, 16'h0200, 1, 4, 9, 0, 16'h0409, 1);
    vecs[12] = ve(vi(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1),
                  1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0);

    // ---------------- reset state (with a push attempted) ----------------
    async_rst = 1'b1;
    drive(1, 5, 6, 1, 1, 1, 16'h5555, 16'h0000, 1, 1);
    tick();
    #2;
    chk("rst_count",      Count, 0);
    chk("rst_inst_ready", InstReady, 1);
    chk("rst_issue_valid", IssueValid, 0);
    chk("rst_used_a",     UsedAsA, 0);
    chk("rst_used_b",     UsedAsB, 0);
    chk("rst_wbw",        WillBeWritingToA, 0);
    chk("rst_mark_dirty", MarkDirty, 0);
    chk("rst_issue_a",    IssueA, 0);
    chk("rst_issue_pl",   IssuePayload, 0);
    tick();
    async_rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].ub, vecs[i].wa, vecs[i].mc,
            vecs[i].pl, vecs[i].dirty, vecs[i].ir, vecs[i].en);
      chk($sformatf("v%0d_inst_ready", i), InstReady, vecs[i].e_ird);
      chk($sformatf("v%0d_used_a", i), UsedAsA, vecs[i].e_ua);
      chk($sformatf("v%0d_used_b", i), UsedAsB, vecs[i].e_ub);
      chk($sformatf("v%0d_wbw", i), WillBeWritingToA, vecs[i].e_wbw);
      chk($sformatf("v%0d_mark_dirty", i), MarkDirty, vecs[i].e_md);
      chk($sformatf("v%0d_issued_a", i), IssuedAsA, vecs[i].e_ia);
      chk($sformatf("v%0d_issued_b", i), IssuedAsB, vecs[i].e_ib);
      chk($sformatf("v%0d_issue_valid", i), IssueValid, vecs[i].e_iv);
      chk($sformatf("v%0d_issue_a", i), IssueA, vecs[i].e_xa);
      chk($sformatf("v%0d_issue_b", i), IssueB, vecs[i].e_xb);
      chk($sformatf("v%0d_issue_mc", i), IssueMultiCycle, vecs[i].e_xmc);
      chk($sformatf("v%0d_issue_pl", i), IssuePayload, vecs[i].e_xpl);
      chk($sformatf("v%0d_count", i), Count, vecs[i].e_cnt);
      tick();
    end

    // ---------------- fill to full, fifth push ignored ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'(i), 0, 0, 0, 0, 16'h0100 + 16'(i), 16'h0000, 0, 1);
      tick();
    end
    drive(1, 9, 0, 0, 0, 0, 16'h0199, 16'h0000, 0, 1);
    chk("full_count",      Count, 4);
    chk("full_inst_ready", InstReady, 0);
    chk("full_used_a",     UsedAsA, 0);
    tick();
    // pop while full with InstValid high: the pop must not admit the push
    drive(1, 9, 0, 0, 0, 0, 16'h0199, 16'h0000, 1, 1);
    chk("full_hold_count", Count, 4);
    chk("full_pop_used_a", UsedAsA, 0);
    chk("full_pop_issued", IssuedAsA, 16'h0001);
    chk("full_pop_pl",     IssuePayload, 16'h0100);
    tick();
    drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
    chk("after_pop_count", Count, 3);
    chk("after_pop_ready", InstReady, 1);
    chk("after_pop_head",  IssuePayload, 16'h0101);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
    chk("drain_count", Count, 0);

    // ---------------- simultaneous push and pop on the same register ----------------
    drive(1, 1, 0, 0, 0, 0, 16'h0201, 16'h0000, 0, 1);
    tick();
    drive(1, 6, 0, 0, 0, 0, 16'h0206, 16'h0000, 0, 1);
    tick();
    drive(1, 1, 0, 0, 0, 0, 16'h0203, 16'h0000, 1, 1);
    chk("pp_count_pre", Count, 2);
    chk("pp_used_a",    UsedAsA, 16'h0002);
    chk("pp_issued_a",  IssuedAsA, 16'h0002);
    chk("pp_pl",        IssuePayload, 16'h0201);
    tick();
    drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
    chk("pp_count_post", Count, 2);
    chk("pp_head_a",     IssueA, 6);
    chk("pp_head_pl",    IssuePayload, 16'h0206);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1);
      tick();
    end

    // ---------------- 10 entries streamed through, pointers wrap ----------------
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 40 && popped < 10; cyc++) begin
      drive(pushed < 10, 4'(pushed), 0, 0, 0, 0, 16'h0300 + 16'(pushed), 16'h0000,
            cyc >= 3, 1);
      chk("wrap_count", Count, mq.size());
      chk("wrap_valid", IssueValid, mq.size() != 0);
      if (cyc >= 3 && mq.size() != 0) begin
        chk("wrap_payload", IssuePayload, mq[0]);
        void'(mq.pop_front());
        popped++;
      end
      if (pushed < 10 && (mq.size() + ((cyc >= 3 && popped > 0) ? 0 : 0)) < 5 &&
          (Count != 3'd4)) begin
        mq.push_back(16'h0300 + 16'(pushed));
        pushed++;
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
    chk("wrap_all_issued", popped, 10);
    chk("wrap_count_end",  Count, 0);
    chk("wrap_valid_end",  IssueValid, 0);

    // ---------------- async reset mid-operation ----------------
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'(i + 2), 0, 0, 0, 0, 16'h0400 + 16'(i), 16'h0000, 0, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
    chk("pre_rst_count", Count, 3);
    #1;
    async_rst  = 1'b1;
    IssueReady = 1'b1;
    #1;
    chk("arst_count",       Count, 0);
    chk("arst_issue_valid", IssueValid, 0);
    chk("arst_issued_a",    IssuedAsA, 0);
    chk("arst_inst_ready",  InstReady, 1);
    chk("arst_issue_pl",    IssuePayload, 0);
    tick();
    #2;
    chk("arst_hold_count",  Count, 0);
    chk("arst_hold_issued", IssuedAsA, 0);
    async_rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1);
    tick();
    #2;
    chk("post_rst_count", Count, 0);
    chk("post_rst_valid", IssueValid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
